census_window_seq: RTL and testbench

Sequencer for the census-transform window datapath in the stereo pipeline. It accepts a raster pixel stream with a valid/ready handshake and tracks the column/row position within the frame. It produces the shift enable and line-buffer address that advance the window registers (chains of synchronous-reset D flip-flops), and emits a registered window-valid beat with centre coordinates once a full WIN_W×WIN_H neighbourhood is resident.

---
 rtl/census_window_seq_pkg.sv | 29 ++
 rtl/census_window_seq_raster_counter.sv | 79 +++++++
 rtl/census_window_seq.sv | 109 ++++++++++
 tb/tb_census_window_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/census_window_seq_pkg.sv
// Shared definitions for the census-window sequencer: state encoding,
// window half-size constants and counter-width helpers.
package census_defs;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  // Half-width/half-height of the default 5x5 census window.
  localparam int WIN_HW_DEF = 2;
  localparam int WIN_HH_DEF = 2;

  // Distance from a window edge to its centre for an odd window size.
  function automatic int win_half(input int n);
    return (n - 1) / 2;
  endfunction

  // Bits needed to hold a column index (0 .. n-1); never narrower than 1.
  function automatic int xb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a row index (0 .. n-1); never narrower than 1.
  function automatic int yb_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/census_window_seq_raster_counter.sv
// Column/row raster position counter plus the synchronous-reset register
// cell used for the sequencer's output stage.
module raster_counter
  import census_defs::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int XB = xb_width(IMG_W),
  localparam int YB = yb_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,      // advance one pixel
  input  logic          origin_i,  // origin pixel accepted: continue from (1,0)
  input  logic          clr_i,     // frame finished: return to (0,0)
  output logic [XB-1:0] col_o,
  output logic [YB-1:0] row_o,
  output logic          last_o     // current position is the final pixel
);

  logic [XB-1:0] col_q, col_d;
  logic [YB-1:0] row_q, row_d;
  logic          col_end;

  assign col_end = (col_q == XB'(IMG_W - 1));
  assign last_o  = col_end && (row_q == YB'(IMG_H - 1));
  assign col_o   = col_q;
  assign row_o   = row_q;

  // Next position: clear beats restart, restart beats advance, plain beats step.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (origin_i) begin
      col_d = XB'(1);
      row_d = '0;
    end else if (en_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + YB'(1);
      end else begin
        col_d = col_q + XB'(1);
      end
    end
  end

  // Position register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// Generic synchronous-reset D flip-flop bank.
module census_sr_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Plain registered stage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/census_window_seq.sv
// Census-window sequencer: tracks raster position of an accepted pixel
// stream, drives the window shift enable / line-buffer address, and emits a
// registered window beat once a full neighbourhood is resident.
module census_window_seq
  import census_defs::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int WIN_W = 5,
  parameter int WIN_H = 5,
  localparam int XB = xb_width(IMG_W),
  localparam int YB = yb_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic          shift_en,
  output logic [XB-1:0] lb_addr,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [XB-1:0] win_col,
  output logic [YB-1:0] win_row,
  output logic          frame_done,
  output logic          sof_err
);

  localparam int WIN_HW = win_half(WIN_W);
  localparam int WIN_HH = win_half(WIN_H);
  localparam int OUT_W  = 3 + XB + YB;

  state_e        state_q, state_d;
  logic [XB-1:0] col_q;
  logic [YB-1:0] row_q;
  logic          last_pix;
  logic          active;
  logic          sof_acc;
  logic          beat_pix;
  logic          complete;

  logic          win_valid_d;
  logic [XB-1:0] win_col_d;
  logic [YB-1:0] win_row_d;
  logic          frame_done_d;
  logic          sof_err_d;

  // A held window beat blocks the stream; there is no skid buffer.
  assign in_ready = !win_valid | win_ready;
  assign shift_en = in_valid & in_ready;
  assign active   = (state_q == ST_ACTIVE);
  assign sof_acc  = shift_en & in_sof;
  // Accepted beat that is an in-frame pixel at the counter position.
  assign beat_pix = shift_en & !in_sof & active;
  assign complete = beat_pix
                  & (col_q >= XB'(WIN_W - 1))
                  & (row_q >= YB'(WIN_H - 1));
  assign lb_addr  = (active || sof_acc) ? col_q : '0;

  raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (beat_pix & !last_pix),
    .origin_i (sof_acc),
    .clr_i    (beat_pix & last_pix),
    .col_o    (col_q),
    .row_o    (row_q),
    .last_o   (last_pix)
  );

  // Next state: any accepted start-of-frame (re)starts a frame; the last pixel ends it.
  always_comb begin
    state_d = state_q;
    if (sof_acc)                  state_d = ST_ACTIVE;
    else if (beat_pix && last_pix) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Output stage next values: load on completion, hold while stalled.
  always_comb begin
    win_valid_d  = complete | (win_valid & !win_ready);
    win_col_d    = win_col;
    win_row_d    = win_row;
    if (complete) begin
      win_col_d = col_q - XB'(WIN_HW);
      win_row_d = row_q - YB'(WIN_HH);
    end
    frame_done_d = beat_pix & last_pix;
    sof_err_d    = sof_acc & active;
  end

  census_sr_dff #(
    .W (OUT_W)
  ) u_out (
    .clk (clk),
    .rst (rst),
    .d_i ({win_valid_d, win_col_d, win_row_d, frame_done_d, sof_err_d}),
    .q_o ({win_valid,   win_col,   win_row,   frame_done,   sof_err})
  );

endmodule

// File: tb/tb_census_window_seq.sv
// Directed bench for census_window_seq on a 6x5 image with a 3x3 window.
module tb_census_window_seq;

  localparam int IMG_W = 6;
  localparam int IMG_H = 5;
  localparam int WIN_W = 3;
  localparam int WIN_H = 3;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic       in_ready;
  logic       shift_en;
  logic [2:0] lb_addr;
  logic       win_valid;
  logic       win_ready;
  logic [2:0] win_col;
  logic [2:0] win_row;
  logic       frame_done;
  logic       sof_err;

  int errors = 0;
  int checks = 0;

  census_window_seq #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN_W (WIN_W),
    .WIN_H (WIN_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .shift_en   (shift_en),
    .lb_addr    (lb_addr),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  // Streams pixels k = start_k .. start_k+nbeats-1 of a frame with win_ready=1
  // (in_sof on k==0) and checks every beat against raster expectations.
  task automatic drive_frame(input int start_k, input int nbeats,
                             output int nwin, output int nfd);
    int c, r;
    bit ew;
    nwin = 0;
    nfd  = 0;
    for (int k = start_k; k < start_k + nbeats; k++) begin
      c = k % IMG_W;
      r = k / IMG_W;
      in_valid  = 1'b1;
      in_sof    = (k == 0);
      win_ready = 1'b1;
      #1;
      checks++;
      if (shift_en !== 1'b1) begin
        errors++;
        $display("FAIL beat_shift_en k=%0d: got %b expected 1", k, shift_en);
      end
      checks++;
      if (lb_addr !== 3'(c)) begin
        errors++;
        $display("FAIL beat_lb_addr k=%0d: got %0d expected %0d", k, lb_addr, c);
      end
      @(posedge clk); #1;
      ew = (c >= WIN_W - 1) && (r >= WIN_H - 1);
      checks++;
      if (win_valid !== ew) begin
        errors++;
        $display("FAIL beat_win_valid k=%0d: got %b expected %b", k, win_valid, ew);
      end
      if (ew) begin
        nwin++;
        checks++;
        if (win_col !== 3'(c - 1) || win_row !== 3'(r - 1)) begin
          errors++;
          $display("FAIL beat_win_pos k=%0d: got (%0d,%0d) expected (%0d,%0d)",
                   k, win_col, win_row, c - 1, r - 1);
        end else begin
          $display("window beat k=%0d centre (%0d,%0d)", k, win_col, win_row);
        end
      end
      checks++;
      if (frame_done !== (k == NPIX - 1)) begin
        errors++;
        $display("FAIL beat_frame_done k=%0d: got %b expected %b", k, frame_done, (k == NPIX - 1));
      end
      if (frame_done === 1'b1) nfd++;
      checks++;
      if (sof_err !== 1'b0) begin
        errors++;
        $display("FAIL beat_sof_err k=%0d: got %b expected 0", k, sof_err);
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || sof_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: got v=%b fd=%b se=%b expected 0 0 0", win_valid, frame_done, sof_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (shift_en !== 1'b0 || lb_addr !== 3'd0) begin
      errors++;
      $display("FAIL reset_shift: got se=%b addr=%0d expected 0 0", shift_en, lb_addr);
    end
    $display("reset done");
  endtask

  task automatic test_frame();
    int nw, nf;
    drive_frame(0, NPIX, nw, nf);
    checks++;
    if (nw !== 12 || nf !== 1) begin
      errors++;
      $display("FAIL frame_counts: got win=%0d fd=%0d expected 12 1", nw, nf);
    end
    $display("frame: %0d windows, %0d frame_done", nw, nf);
  endtask

  task automatic test_idle_discard();
    int nw, nf;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; win_ready = 1'b1;
      #1;
      checks++;
      if (shift_en !== 1'b1 || lb_addr !== 3'd0) begin
        errors++;
        $display("FAIL idle_shift: got se=%b addr=%0d expected 1 0", shift_en, lb_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs: got v=%b fd=%b expected 0 0", win_valid, frame_done);
      end
      $display("idle discard beat %0d", i);
    end
    in_valid = 1'b0;
    drive_frame(0, NPIX, nw, nf);
    checks++;
    if (nw !== 12 || nf !== 1) begin
      errors++;
      $display("FAIL idle_frame_counts: got win=%0d fd=%0d expected 12 1", nw, nf);
    end
  endtask

  task automatic test_stall();
    int nw1, nf1, nw2, nf2, nmid;
    drive_frame(0, 15, nw1, nf1);      // ends on pixel (2,2): window (1,1) held
    in_valid = 1'b1; in_sof = 1'b0; win_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0 || shift_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_block cyc=%0d: got rdy=%b se=%b expected 0 0", i, in_ready, shift_en);
      end
      @(posedge clk); #1;
      checks++;
      if (win_valid !== 1'b1 || win_col !== 3'd1 || win_row !== 3'd1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: got v=%b (%0d,%0d) expected 1 (1,1)", i, win_valid, win_col, win_row);
      end
      $display("stall cycle %0d", i);
    end
    win_ready = 1'b1;
    #1;
    checks++;
    if (shift_en !== 1'b1 || lb_addr !== 3'd3) begin
      errors++;
      $display("FAIL stall_release: got se=%b addr=%0d expected 1 3", shift_en, lb_addr);
    end
    @(posedge clk); #1;
    nmid = 0;
    checks++;
    if (win_valid !== 1'b1 || win_col !== 3'd2 || win_row !== 3'd1) begin
      errors++;
      $display("FAIL stall_next_win: got v=%b (%0d,%0d) expected 1 (2,1)", win_valid, win_col, win_row);
    end else begin
      nmid = 1;
    end
    drive_frame(16, NPIX - 16, nw2, nf2);
    checks++;
    if (nw1 + nmid + nw2 !== 12 || nf2 !== 1) begin
      errors++;
      $display("FAIL stall_counts: got win=%0d fd=%0d expected 12 1", nw1 + nmid + nw2, nf2);
    end
  endtask

  task automatic test_sof_mid();
    int nw, nf;
    drive_frame(0, 15, nw, nf);
    in_valid = 1'b1; in_sof = 1'b1; win_ready = 1'b1;   // restart at pixel (3,2)
    #1;
    checks++;
    if (shift_en !== 1'b1) begin
      errors++;
      $display("FAIL sof_mid_shift: got %b expected 1", shift_en);
    end
    @(posedge clk); #1;
    checks++;
    if (sof_err !== 1'b1 || frame_done !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL sof_mid_pulse: got se=%b fd=%b v=%b expected 1 0 0", sof_err, frame_done, win_valid);
    end
    $display("sof mid-frame restart");
    drive_frame(1, NPIX - 1, nw, nf);
    checks++;
    if (nw !== 12 || nf !== 1) begin
      errors++;
      $display("FAIL sof_mid_counts: got win=%0d fd=%0d expected 12 1", nw, nf);
    end
  endtask

  task automatic test_sof_last();
    int nw, nf;
    drive_frame(0, NPIX - 1, nw, nf);
    in_valid = 1'b1; in_sof = 1'b1; win_ready = 1'b1;   // in_sof on pixel (5,4)
    @(posedge clk); #1;
    checks++;
    if (sof_err !== 1'b1 || frame_done !== 1'b0 || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL sof_last_pulse: got se=%b fd=%b v=%b expected 1 0 0", sof_err, frame_done, win_valid);
    end
    $display("sof on last pixel restart");
    drive_frame(1, NPIX - 1, nw, nf);
    checks++;
    if (nw !== 12 || nf !== 1) begin
      errors++;
      $display("FAIL sof_last_counts: got win=%0d fd=%0d expected 12 1", nw, nf);
    end
  endtask

  task automatic test_rst_mid();
    int nw, nf;
    drive_frame(0, 22, nw, nf);          // window from (3,3) pending
    in_valid = 1'b1; in_sof = 1'b0; win_ready = 1'b1; rst = 1'b1;   // at pixel (4,3)
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || sof_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_regs: got v=%b fd=%b se=%b rdy=%b expected 0 0 0 1",
               win_valid, frame_done, sof_err, in_ready);
    end
    #1;
    checks++;
    if (lb_addr !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid_idle_addr: got %0d expected 0", lb_addr);
    end
    @(posedge clk); #1;
    checks++;
    if (win_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle_win: got %b expected 0", win_valid);
    end
    in_valid = 1'b0;
    $display("reset mid-frame");
    drive_frame(0, NPIX, nw, nf);
    checks++;
    if (nw !== 12 || nf !== 1) begin
      errors++;
      $display("FAIL rst_mid_counts: got win=%0d fd=%0d expected 12 1", nw, nf);
    end
  endtask

  task automatic test_back_to_back();
    int nw, nf;
    for (int f = 0; f < 2; f++) begin
      drive_frame(0, NPIX, nw, nf);
      checks++;
      if (nw !== 12 || nf !== 1) begin
        errors++;
        $display("FAIL b2b_counts f=%0d: got win=%0d fd=%0d expected 12 1", f, nw, nf);
      end
      $display("back-to-back frame %0d: %0d windows", f, nw);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_idle_discard();
    test_stall();
    test_sof_mid();
    test_sof_last();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
